// File: rtl/alu_seq_hs.sv
// alu_seq_hs: valid/ready handshaked N-bit ALU with registered results,
// single-cycle logic/arith ops and iterative shift-add multiply / restoring divide.
module alu_seq_hs #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] upper_result,
  output logic [6:0]   flags,
  output logic         busy
);
  localparam int            SW       = $clog2(N);
  localparam logic [SW-1:0] CNT_LAST = SW'(N - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_r, state_next_s;
  logic [3:0]     op_r;
  logic [N-1:0]   a_r, b_r;
  logic [N-1:0]   acc_hi_r, acc_lo_r;
  logic [SW-1:0]  cnt_r;
  logic [N-1:0]   result_r, upper_r;
  logic [6:0]     flags_r;

  logic [N:0]     sum_s, diff_s;
  logic [SW-1:0]  sh_s;
  logic [N-1:0]   sc_res_s, sc_up_s;
  logic           sc_carry_s, sc_ovf_s, sc_ill_s, sc_div0_s;
  logic           go_calc_s;
  logic [N:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic           div_ge_s;
  logic [N-1:0]   step_hi_s, step_lo_s;

  function automatic logic parity_of(input logic [N-1:0] v);
    return ^v;
  endfunction

  function automatic logic [6:0] pack_flags(input logic [N-1:0] res, input logic [N-1:0] up,
                                            input logic illegal, input logic div0,
                                            input logic ovf, input logic carry);
    logic zero_v;
    zero_v = (res == {N{1'b0}}) && (up == {N{1'b0}});
    return {illegal, div0, parity_of(res), res[N-1], zero_v, ovf, carry};
  endfunction

  // Single-cycle datapath, evaluated on the live operands in the accept cycle
  always_comb begin
    sum_s      = {1'b0, a} + {1'b0, b};
    diff_s     = {1'b0, a} - {1'b0, b};
    sh_s       = b[SW-1:0];
    sc_res_s   = {N{1'b0}};
    sc_up_s    = {N{1'b0}};
    sc_carry_s = 1'b0;
    sc_ovf_s   = 1'b0;
    sc_ill_s   = 1'b0;
    sc_div0_s  = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res_s   = sum_s[N-1:0];
        sc_carry_s = sum_s[N];
        sc_ovf_s   = (a[N-1] == b[N-1]) && (sum_s[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sc_res_s   = diff_s[N-1:0];
        sc_carry_s = diff_s[N];
        sc_ovf_s   = (a[N-1] != b[N-1]) && (diff_s[N-1] != a[N-1]);
      end
      OP_AND:  sc_res_s = a & b;
      OP_OR:   sc_res_s = a | b;
      OP_XOR:  sc_res_s = a ^ b;
      OP_SLL:  sc_res_s = a << sh_s;
      OP_SRL:  sc_res_s = a >> sh_s;
      OP_SRA:  sc_res_s = $signed(a) >>> sh_s;
      OP_SLT:  sc_res_s = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res_s = {{(N-1){1'b0}}, (a < b)};
      OP_MULU: sc_res_s = {N{1'b0}};
      OP_DIVU: begin
        if (b == {N{1'b0}}) begin
          sc_res_s  = {N{1'b1}};
          sc_up_s   = a;
          sc_div0_s = 1'b1;
        end else begin
          sc_res_s  = {N{1'b0}};
        end
      end
      default: sc_ill_s = 1'b1;
    endcase
    go_calc_s = (op == OP_MULU) || ((op == OP_DIVU) && (b != {N{1'b0}}));
  end

  // One shift-add (MULU) or restoring-subtract (DIVU) iteration
  always_comb begin
    mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, a_r} : {(N+1){1'b0}});
    div_shift_s = {acc_hi_r, acc_lo_r[N-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    div_ge_s    = (div_shift_s >= {1'b0, b_r});
    if (op_r == OP_MULU) begin
      step_hi_s = mul_sum_s[N:1];
      step_lo_s = {mul_sum_s[0], acc_lo_r[N-1:1]};
    end else begin
      step_hi_s = div_ge_s ? div_diff_s[N-1:0] : div_shift_s[N-1:0];
      step_lo_s = {acc_lo_r[N-2:0], div_ge_s};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = go_calc_s ? ST_CALC : ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state flops only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: in_ready  = 1'b1;
      ST_CALC: busy      = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand capture, iteration state and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= 4'd0;
      a_r      <= {N{1'b0}};
      b_r      <= {N{1'b0}};
      acc_hi_r <= {N{1'b0}};
      acc_lo_r <= {N{1'b0}};
      cnt_r    <= {SW{1'b0}};
      result_r <= {N{1'b0}};
      upper_r  <= {N{1'b0}};
      flags_r  <= 7'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            cnt_r <= {SW{1'b0}};
            if (go_calc_s) begin
              acc_hi_r <= {N{1'b0}};
              acc_lo_r <= (op == OP_MULU) ? b : a;
            end else begin
              result_r <= sc_res_s;
              upper_r  <= sc_up_s;
              flags_r  <= pack_flags(sc_res_s, sc_up_s, sc_ill_s, sc_div0_s, sc_ovf_s, sc_carry_s);
            end
          end
        end
        ST_CALC: begin
          acc_hi_r <= step_hi_s;
          acc_lo_r <= step_lo_s;
          cnt_r    <= cnt_r + SW'(1);
          if (cnt_r == CNT_LAST) begin
            result_r <= step_lo_s;
            upper_r  <= step_hi_s;
            flags_r  <= pack_flags(step_lo_s, step_hi_s, 1'b0, 1'b0, 1'b0, 1'b0);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign result       = result_r;
  assign upper_result = upper_r;
  assign flags        = flags_r;

endmodule

// File: tb/tb_alu_seq_hs.sv
// Directed bench for alu_seq_hs: N=8 instance for hand-computed vectors,
// N=64 instance for a short random smoke run against SystemVerilog arithmetic.
module tb_alu_seq_hs;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] op;
  logic [7:0] a, b, result, upper_result;
  logic [6:0] flags;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
  logic [3:0]  w_op;
  logic [63:0] w_a, w_b, w_result, w_upper;
  logic [6:0]  w_flags;

  int checks = 0;
  int failures = 0;

  alu_seq_hs #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .upper_result(upper_result), .flags(flags), .busy(busy)
  );

  alu_seq_hs #(.N(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
    .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
    .upper_result(w_upper), .flags(w_flags), .busy(w_busy)
  );

  // Issue one operation, scramble operands after accept, wait for out_valid
  task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int lat, output int busy_cyc);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = ~x; b = ~y; op = 4'd0;
    lat = 1; busy_cyc = 0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take8(output logic rdy_after, output logic ov_after);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rdy_after = in_ready;
    ov_after = out_valid;
  endtask

  task automatic run64(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                       output int lat);
    @(negedge clk);
    w_op = o; w_a = x; w_b = y; w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0; w_a = ~x; w_b = ~y;
    lat = 1;
    while (!w_out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = 8'h00; b = 8'h00;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_op = 4'd0; w_a = 64'd0; w_b = 64'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, result, upper_result, flags} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 7'd0}) begin
      failures++;
      $display("FAIL reset_state got=%h expected=%h", {in_ready, out_valid, busy, result, upper_result, flags},
               {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 7'd0});
    end
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    int lat, bc;
    logic r, v;
    run8(OP_ADD, 8'hFF, 8'h01, lat, bc);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d expected=1", lat); end
    checks++;
    if ({upper_result, result, flags} !== {8'h00, 8'h00, 7'b0000101}) begin
      failures++;
      $display("FAIL add_wrap got=%h expected=%h", {upper_result, result, flags}, {8'h00, 8'h00, 7'b0000101});
    end
    take8(r, v);
    checks++;
    if ({r, v} !== 2'b10) begin failures++; $display("FAIL take_release got=%b expected=10", {r, v}); end
    run8(OP_SUB, 8'h80, 8'h01, lat, bc);
    checks++;
    if ({upper_result, result, flags} !== {8'h00, 8'h7F, 7'b0010010}) begin
      failures++;
      $display("FAIL sub_ovf got=%h expected=%h", {upper_result, result, flags}, {8'h00, 8'h7F, 7'b0010010});
    end
    take8(r, v);
    run8(OP_ADD, 8'h7F, 8'h01, lat, bc);
    checks++;
    if ({upper_result, result, flags} !== {8'h00, 8'h80, 7'b0011010}) begin
      failures++;
      $display("FAIL add_ovf got=%h expected=%h", {upper_result, result, flags}, {8'h00, 8'h80, 7'b0011010});
    end
    take8(r, v);
  endtask

  task automatic test_mul();
    int lat, bc;
    logic r, v;
    run8(OP_MULU, 8'hFF, 8'hFF, lat, bc);
    checks++;
    if (lat !== 9 || bc !== 8) begin
      failures++;
      $display("FAIL mul_timing got lat=%0d busy=%0d expected lat=9 busy=8", lat, bc);
    end
    checks++;
    if ({upper_result, result, flags} !== {8'hFE, 8'h01, 7'b0010000}) begin
      failures++;
      $display("FAIL mul_ff got=%h expected=%h", {upper_result, result, flags}, {8'hFE, 8'h01, 7'b0010000});
    end
    take8(r, v);
  endtask

  task automatic test_div();
    int lat, bc;
    logic r, v;
    run8(OP_DIVU, 8'hC8, 8'h07, lat, bc);
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL div_latency got=%0d expected=9", lat); end
    checks++;
    if ({upper_result, result, flags} !== {8'h04, 8'h1C, 7'b0010000}) begin
      failures++;
      $display("FAIL div_c8_7 got=%h expected=%h", {upper_result, result, flags}, {8'h04, 8'h1C, 7'b0010000});
    end
    take8(r, v);
    run8(OP_DIVU, 8'h35, 8'h00, lat, bc);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL div0_latency got=%0d expected=1", lat); end
    checks++;
    if ({upper_result, result, flags} !== {8'h35, 8'hFF, 7'b0101000}) begin
      failures++;
      $display("FAIL div0 got=%h expected=%h", {upper_result, result, flags}, {8'h35, 8'hFF, 7'b0101000});
    end
    take8(r, v);
  endtask

  task automatic test_shift_slt();
    int lat, bc;
    logic r, v;
    run8(OP_SRA, 8'h90, 8'h0B, lat, bc);
    checks++;
    if ({upper_result, result, flags} !== {8'h00, 8'hF2, 7'b0011000}) begin
      failures++;
      $display("FAIL sra got=%h expected=%h", {upper_result, result, flags}, {8'h00, 8'hF2, 7'b0011000});
    end
    take8(r, v);
    run8(OP_SLL, 8'h03, 8'h0A, lat, bc);
    checks++;
    if ({upper_result, result, flags} !== {8'h00, 8'h0C, 7'b0000000}) begin
      failures++;
      $display("FAIL sll got=%h expected=%h", {upper_result, result, flags}, {8'h00, 8'h0C, 7'b0000000});
    end
    take8(r, v);
    run8(OP_SLT, 8'hFF, 8'h01, lat, bc);
    checks++;
    if ({upper_result, result, flags} !== {8'h00, 8'h01, 7'b0010000}) begin
      failures++;
      $display("FAIL slt got=%h expected=%h", {upper_result, result, flags}, {8'h00, 8'h01, 7'b0010000});
    end
    take8(r, v);
    run8(OP_SLTU, 8'hFF, 8'h01, lat, bc);
    checks++;
    if ({upper_result, result, flags} !== {8'h00, 8'h00, 7'b0000100}) begin
      failures++;
      $display("FAIL sltu got=%h expected=%h", {upper_result, result, flags}, {8'h00, 8'h00, 7'b0000100});
    end
    take8(r, v);
  endtask

  task automatic test_illegal();
    int lat, bc;
    logic r, v;
    run8(4'd13, 8'h5A, 8'hA5, lat, bc);
    checks++;
    if (lat !== 1 || {upper_result, result, flags} !== {8'h00, 8'h00, 7'b1000100}) begin
      failures++;
      $display("FAIL illegal got lat=%0d vals=%h expected lat=1 vals=%h", lat,
               {upper_result, result, flags}, {8'h00, 8'h00, 7'b1000100});
    end
    take8(r, v);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic r, v;
    run8(OP_ADD, 8'h12, 8'h34, lat, bc);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; op = OP_SUB; a = 8'(k); b = 8'h55;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, upper_result, result, flags} !== {1'b1, 1'b0, 8'h00, 8'h46, 7'b0010000}) begin
        failures++;
        $display("FAIL backpressure_hold cycle=%0d got=%h expected=%h", k,
                 {out_valid, in_ready, upper_result, result, flags}, {1'b1, 1'b0, 8'h00, 8'h46, 7'b0010000});
      end
    end
    in_valid = 1'b0;
    take8(r, v);
    checks++;
    if ({r, v} !== 2'b10) begin failures++; $display("FAIL backpressure_release got=%b expected=10", {r, v}); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    op = OP_MULU; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b expected=1", busy); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, result, upper_result, flags} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 7'd0}) begin
      failures++;
      $display("FAIL mid_reset got=%h expected=%h", {in_ready, out_valid, busy, result, upper_result, flags},
               {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 7'd0});
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_output got=%b expected=0", seen); end
  endtask

  task automatic test_n64_smoke();
    int lat;
    logic [63:0]  x, y;
    logic [127:0] p;
    for (int i = 0; i < 3; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      run64(OP_ADD, x, y, lat);
      checks++;
      if (lat !== 1 || w_result !== x + y || w_upper !== 64'd0) begin
        failures++;
        $display("FAIL n64_add got lat=%0d r=%h u=%h expected lat=1 r=%h u=0", lat, w_result, w_upper, x + y);
      end
      p = {64'd0, x} * {64'd0, y};
      run64(OP_MULU, x, y, lat);
      checks++;
      if (lat !== 65 || {w_upper, w_result} !== p) begin
        failures++;
        $display("FAIL n64_mul got lat=%0d v=%h expected lat=65 v=%h", lat, {w_upper, w_result}, p);
      end
      y = {32'd0, $urandom} | 64'd1;
      run64(OP_DIVU, x, y, lat);
      checks++;
      if (lat !== 65 || w_result !== x / y || w_upper !== x % y) begin
        failures++;
        $display("FAIL n64_div got lat=%0d q=%h r=%h expected lat=65 q=%h r=%h", lat, w_result, w_upper,
                 x / y, x % y);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_shift_slt();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_n64_smoke();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
